// File: rtl/oled_init_sequencer.sv
// ---------------------------------------------------------------------------
// oled_init_sequencer
// Walks a power-up sequence ROM for an SPI OLED panel. It pulses the panel
// reset, then offers command and data bytes to an SPI shifter, inserts the
// timed delays, and switches VBAT on when the sequence asks for it.
//
// Ports
//   clk_in      : clock, rising edge
//   reset       : synchronous active-high reset; releasing it starts a sequence
//   start       : single-cycle re-init request, honoured only when done
//   rom_addr    : address of the current sequence entry
//   rom_data    : entry at rom_addr (same cycle); [9:8] type, [7:0] payload
//   rom_last    : rom_addr holds the final entry
//   cmd_valid   : byte offered to the shifter
//   cmd_ready   : shifter accepts the byte (with cmd_valid) at a rising edge
//   cmd_data    : byte to shift
//   cmd_dc      : D/C level, 0 = command, 1 = data
//   done / busy : sequence complete / in progress (busy = !done)
//   oled_rstn   : panel reset, active-low
//   oled_vbatn  : panel VBAT enable, active-low
//   oled_csn    : panel chip select, active-low
//
// The cmd_* outputs decode the ROM word in the same cycle the address is
// presented, so they are combinational from state_q and rom_data; they are
// forced low while reset is high so no byte can be taken during an abort.
// ---------------------------------------------------------------------------
module oled_init_sequencer #(
   parameter int unsigned RST_PULSE_CYC = 16,
   parameter int unsigned DELAY_UNIT    = 1000,
   parameter int unsigned ROM_DEPTH     = 32,
   localparam int unsigned ADDR_W       = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [9:0]        rom_data,
   input  logic              rom_last,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [7:0]        cmd_data,
   output logic              cmd_dc,
   output logic              done,
   output logic              busy,
   output logic              oled_rstn,
   output logic              oled_vbatn,
   output logic              oled_csn
);

   // Counter must hold the longest delay (payload 255) or the reset pulse.
   localparam int unsigned DLY_MAX = 255 * DELAY_UNIT;
   localparam int unsigned CNT_MAX = (RST_PULSE_CYC > DLY_MAX) ? RST_PULSE_CYC : DLY_MAX;
   localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam int unsigned LAST_A  = (ROM_DEPTH > 0) ? ROM_DEPTH - 1 : 0;

   typedef enum logic [1:0] {
      ST_RST_PULSE = 2'd0,
      ST_SEND      = 2'd1,
      ST_DELAY     = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rstn_q, rstn_d;
   logic              vbatn_q, vbatn_d;
   logic              csn_q, csn_d;
   logic              done_q, done_d;

   logic              is_delay_c;
   logic              is_end_c;
   logic              hs_c;

   // Entry decode and handshake.
   assign is_delay_c = rom_data[9];
   assign is_end_c   = rom_last || (addr_q == ADDR_W'(LAST_A));
   assign cmd_valid  = !reset && (state_q == ST_SEND) && !is_delay_c;
   assign cmd_data   = cmd_valid ? rom_data[7:0] : 8'h00;
   assign cmd_dc     = cmd_valid ? rom_data[8] : 1'b0;
   assign hs_c       = cmd_valid && cmd_ready;

   // Next-state, counter, address and registered panel controls.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      vbatn_d = vbatn_q;

      unique case (state_q)
         ST_RST_PULSE: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_SEND;
               addr_d  = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SEND: begin
            if (is_delay_c) begin
               cnt_d   = CNT_W'(rom_data[7:0]) * CNT_W'(DELAY_UNIT);
               state_d = ST_DELAY;
               // Type 11 switches VBAT on for the whole remaining sequence.
               if (rom_data[8]) begin
                  vbatn_d = 1'b0;
               end
            end else if (hs_c) begin
               if (is_end_c) begin
                  state_d = ST_DONE;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         ST_DELAY: begin
            if (cnt_q == '0) begin
               if (is_end_c) begin
                  state_d = ST_DONE;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = ST_SEND;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_RST_PULSE;
               cnt_d   = CNT_W'(RST_PULSE_CYC);
               addr_d  = '0;
               vbatn_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_RST_PULSE;
            cnt_d   = CNT_W'(RST_PULSE_CYC);
            addr_d  = '0;
            vbatn_d = 1'b1;
         end
      endcase

      rstn_d = (state_d != ST_RST_PULSE);
      csn_d  = !((state_d == ST_SEND) || (state_d == ST_DELAY));
      done_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= ST_RST_PULSE;
         cnt_q   <= CNT_W'(RST_PULSE_CYC);
         addr_q  <= '0;
         rstn_q  <= 1'b0;
         vbatn_q <= 1'b1;
         csn_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rstn_q  <= rstn_d;
         vbatn_q <= vbatn_d;
         csn_q   <= csn_d;
         done_q  <= done_d;
      end
   end

   assign rom_addr   = addr_q;
   assign oled_rstn  = rstn_q;
   assign oled_vbatn = vbatn_q;
   assign oled_csn   = csn_q;
   assign done       = done_q;
   assign busy       = !done_q;

endmodule

// File: doc/oled_init_sequencer.md
OLED_INIT_SEQUENCER -- requirements
Module: oled_init_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 16: cycles oled_rstn is held low after reset release or restart.
REQ-002 SHALL have parameter DELAY_UNIT, default 1000: clk_in cycles per delay-entry count.
REQ-003 SHALL have parameter ROM_DEPTH, default 32: maximum sequence entries; ADDR_W = clog2(ROM_DEPTH) is derived.
REQ-004 clk_in  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high; also starts a fresh init sequence when released.
REQ-006 start  input  1  single-cycle re-init request.
REQ-007 rom_addr  output  ADDR_W  address of the current sequence entry.
REQ-008 rom_data  input  10  entry at rom_addr, combinational, same-cycle; [9:8] type, [7:0] payload.
REQ-009 rom_last  input  1  high when rom_addr holds the final entry.
REQ-010 cmd_valid  output  1  byte offered to the SPI shifter.
REQ-011 cmd_ready  input  1  shifter accepts the byte when high together with cmd_valid at a rising edge.
REQ-012 cmd_data  output  8  byte to shift.
REQ-013 cmd_dc  output  1  D/C level for cmd_data: 0 = command, 1 = data.
REQ-014 done  output  1  sequence complete.
REQ-015 busy  output  1  sequence in progress; always equals !done.
REQ-016 oled_rstn  output  1  panel reset, active-low.
REQ-017 oled_vbatn  output  1  panel VBAT enable, active-low.
REQ-018 oled_csn  output  1  panel chip select, active-low.

Function
REQ-019 Entry types: 00 = command byte (dc=0); 01 = data byte (dc=1); 10 = delay of payload*DELAY_UNIT cycles; 11 = VBAT on, then the same delay as type 10.
REQ-020 States: RST_PULSE, SEND, DELAY, DONE; no other reachable state.
REQ-021 RST_PULSE: oled_rstn=0 and counter decrements; after exactly RST_PULSE_CYC cycles go to SEND with rom_addr=0.
REQ-022 SEND, type 00/01: cmd_valid=1, cmd_data=payload, cmd_dc=type[0]; all three stay stable until the handshake.
REQ-023 SEND, type 00/01, handshake: if rom_last, go to DONE; otherwise increment rom_addr and stay in SEND. Back-to-back bytes are allowed, one per cycle.
REQ-024 SEND, type 10/11: cmd_valid=0; in the same cycle load counter = payload*DELAY_UNIT and go to DELAY.
REQ-025 Type 11: oled_vbatn drives 0 from the first DELAY cycle and stays 0 until reset or restart.
REQ-026 DELAY: cmd_valid=0; counter decrements each cycle.
REQ-027 DELAY exit: when counter==0, advance as in REQ-023; total DELAY dwell is payload*DELAY_UNIT+1 cycles (payload 0 gives 1 cycle).
REQ-028 The counter SHALL be wide enough for max(RST_PULSE_CYC, 255*DELAY_UNIT) with no wrap.
REQ-029 Address limit: if rom_addr==ROM_DEPTH-1 completes without rom_last, treat it as last and go to DONE; never wrap to 0.
REQ-030 oled_csn=0 in SEND and DELAY, 1 in RST_PULSE and DONE.
REQ-031 DONE: done=1, cmd_valid=0, rom_addr holds its value.
REQ-032 start in DONE: next cycle go to RST_PULSE, with oled_vbatn=1, oled_rstn=0, counter reloaded and rom_addr=0.
REQ-033 start in any state other than DONE SHALL be ignored.
REQ-034 cmd_ready while cmd_valid=0 SHALL be ignored.

Reset
REQ-035 While reset is high: state=RST_PULSE, counter=RST_PULSE_CYC, rom_addr=0, oled_rstn=0, oled_vbatn=1, oled_csn=1, cmd_valid=0, cmd_data=0, cmd_dc=0, done=0.
REQ-036 Reset asserted in any state, including mid-delay or mid-handshake, SHALL abort within one cycle with no partial byte accepted.
REQ-037 The RST_PULSE_CYC count starts on the first cycle after reset falls.

Verification
REQ-038 RST_PULSE_CYC=4, release reset -> oled_rstn low exactly 4 further cycles, then cmd_valid=1 with cmd_data=rom[0][7:0], rom_addr=0.
REQ-039 rom[0]=0x0AE, cmd_ready low 3 cycles then high -> cmd_data=0xAE and rom_addr=0 held 4 cycles; rom_addr=1 after the handshake.
REQ-040 DELAY_UNIT=10, entry 0x202 -> cmd_valid low for 22 cycles (1 SEND + 21 DELAY), then the next entry is offered.
REQ-041 Entry 0x300 -> oled_vbatn falls on the first DELAY cycle; 1 DELAY cycle; vbatn stays 0 through DONE.
REQ-042 rom_last on data entry 0x155 -> cmd_dc=1, done=1 and oled_csn=1 the cycle after the handshake; start pulse -> oled_vbatn=1, oled_rstn=0 next cycle.
REQ-043 Reset asserted mid-DELAY -> next cycle all outputs at their REQ-035 values; start pulsed during SEND -> no effect.
